soafa_cim_macro: RTL and testbench



---
 rtl/soafa_cim_macro_pkg.sv | 22 ++
 rtl/soafa_adder.sv | 28 ++
 rtl/soafa_cim_macro.sv | 67 ++++++
 tb/tb_soafa_cim_macro.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/soafa_cim_macro_pkg.sv
// Shared defaults and mode decoding for the SOAFA compute-in-memory macro.
// Pure definitions; no logic, no latency, no flow control.
package soafa_cim_macro_pkg;

  localparam int DEF_COLS        = 64;
  localparam int DEF_ROWS        = 2;
  localparam int DEF_APPROX_BITS = 8;

  typedef enum logic [1:0] {
    MODE_IDLE    = 2'd0,
    MODE_WRITE   = 2'd1,
    MODE_COMPUTE = 2'd2,
    MODE_READ    = 2'd3
  } mode_e;

  // WE picks write vs read side; wb qualifies the write or picks compute over raw read.
  function automatic mode_e decode_mode(input logic we, input logic wb);
    if (we) return wb ? MODE_WRITE : MODE_IDLE;
    else    return wb ? MODE_COMPUTE : MODE_READ;
  endfunction

endpackage

// File: rtl/soafa_adder.sv
// Approximate adder: OR-ed low bits, exact ripple above with a carry guessed from the top approximate bit.
// Purely combinational, zero latency, no backpressure; carry-out is dropped.
module soafa_adder #(
  parameter int COLS        = 64,
  parameter int APPROX_BITS = 8
) (
  input  logic [COLS-1:0] a,
  input  logic [COLS-1:0] b,
  output logic [COLS-1:0] s
);

  localparam int HI = COLS - APPROX_BITS;

  generate
    if (APPROX_BITS == 0) begin : g_exact
      assign s = a + b;
    end else if (APPROX_BITS >= COLS) begin : g_all_approx
      assign s = a | b;
    end else begin : g_split
      logic carry;
      assign carry              = a[APPROX_BITS-1] & b[APPROX_BITS-1];
      assign s[APPROX_BITS-1:0] = a[APPROX_BITS-1:0] | b[APPROX_BITS-1:0];
      assign s[COLS-1:APPROX_BITS] = a[COLS-1:APPROX_BITS] + b[COLS-1:APPROX_BITS]
                                   + HI'(carry);
    end
  endgenerate

endmodule

// File: rtl/soafa_cim_macro.sv
// ROWS x COLS differential-write SRAM macro with raw read and approximate row+operand compute.
// Reads/computes land in DOut one cycle later; always ready, DOut holds on write/idle cycles.
module soafa_cim_macro
  import soafa_cim_macro_pkg::*;
#(
  parameter int COLS        = DEF_COLS,
  parameter int ROWS        = DEF_ROWS,
  parameter int APPROX_BITS = DEF_APPROX_BITS
) (
  input  logic                      Clk,
  input  logic                      Rst,
  input  logic                      WE,
  input  logic [COLS-1:0]           BL,
  input  logic [COLS-1:0]           BLB,
  input  logic [$clog2(ROWS)-1:0]   Addr,
  input  logic [ROWS*COLS-1:0]      WL,
  input  logic [ROWS*COLS-1:0]      In_B,
  input  logic                      wb,
  output logic [COLS-1:0]           DOut
);

  logic [COLS-1:0] mem     [ROWS];
  logic [COLS-1:0] wl_row  [ROWS];
  logic [COLS-1:0] opd_row [ROWS];
  logic [COLS-1:0] wl_sel;
  logic [COLS-1:0] row_masked;
  logic [COLS-1:0] sum;
  mode_e           mode;

  for (genvar r = 0; r < ROWS; r++) begin : g_slice
    assign wl_row[r]  = WL[r*COLS +: COLS];
    assign opd_row[r] = In_B[r*COLS +: COLS];
  end

  assign mode       = decode_mode(WE, wb);
  assign wl_sel     = wl_row[Addr];
  assign row_masked = mem[Addr] & wl_sel;

  soafa_adder #(
    .COLS        (COLS),
    .APPROX_BITS (APPROX_BITS)
  ) u_adder (
    .a (row_masked),
    .b (opd_row[Addr]),
    .s (sum)
  );

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      for (int r = 0; r < ROWS; r++) mem[r] <= '0;
      DOut <= '0;
    end else begin
      case (mode)
        MODE_WRITE: begin
          // A cell only flips when its word line is on and the bitline pair is a valid differential.
          for (int c = 0; c < COLS; c++) begin
            if (wl_sel[c] && (BL[c] != BLB[c])) mem[Addr][c] <= BL[c];
          end
        end
        MODE_COMPUTE: DOut <= sum;
        MODE_READ:    DOut <= row_masked;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_soafa_cim_macro.sv
module tb_soafa_cim_macro;

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] ZERO = 64'h0;

  logic         Clk = 1'b0;
  logic         Rst;
  logic         WE;
  logic [63:0]  BL;
  logic [63:0]  BLB;
  logic [0:0]   Addr;
  logic [127:0] WL;
  logic [127:0] In_B;
  logic         wb;
  logic [63:0]  DOut;

  int tests = 0;
  int fails = 0;

  soafa_cim_macro dut (
    .Clk  (Clk),
    .Rst  (Rst),
    .WE   (WE),
    .BL   (BL),
    .BLB  (BLB),
    .Addr (Addr),
    .WL   (WL),
    .In_B (In_B),
    .wb   (wb),
    .DOut (DOut)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input logic a, input logic [63:0] bl, input logic [63:0] blb,
                          input logic [127:0] wl);
    WE = 1'b1; wb = 1'b1; Addr = a; BL = bl; BLB = blb; WL = wl;
    tick();
  endtask

  task automatic do_read(input logic a, input logic [127:0] wl);
    WE = 1'b0; wb = 1'b0; Addr = a; WL = wl;
    tick();
  endtask

  task automatic do_compute(input logic a, input logic [127:0] wl, input logic [127:0] inb);
    WE = 1'b0; wb = 1'b1; Addr = a; WL = wl; In_B = inb;
    tick();
  endtask

  initial begin
    Rst = 1'b0; WE = 1'b1; wb = 1'b1; Addr = 1'b0;
    BL = ONES; BLB = ZERO; WL = {ONES, ONES}; In_B = '0;

    // Reset held while a full write is attempted on row 0
    #500;
    check("reset_dout", DOut, ZERO);

    WE = 1'b1; wb = 1'b0;
    Rst = 1'b1;
    tick();
    check("post_reset_we_hold", DOut, ZERO);

    do_read(1'b0, {ONES, ONES});
    check("reset_row0_clear", DOut, ZERO);
    do_read(1'b1, {ONES, ONES});
    check("reset_row1_clear", DOut, ZERO);

    // Write row 1 all ones, row 0 must not change
    do_write(1'b1, ONES, ZERO, {ONES, ONES});
    check("write_dout_hold0", DOut, ZERO);
    do_read(1'b1, {ONES, ONES});
    check("raw_read_row1", DOut, ONES);

    // DOut holds through a write cycle after a nonzero read
    do_write(1'b0, ONES, ONES, {ONES, ONES});
    check("write_dout_hold1", DOut, ONES);
    do_read(1'b0, {ONES, ONES});
    check("invalid_diff_row0", DOut, ZERO);

    // WE=1, wb=0 with valid bitlines: no write
    WE = 1'b1; wb = 1'b0; Addr = 1'b0; BL = ONES; BLB = ZERO; WL = {ONES, ONES};
    tick();
    do_read(1'b0, {ONES, ONES});
    check("we_no_wb_no_write", DOut, ZERO);

    do_write(1'b0, ONES, ZERO, {ONES, 64'h0000_0000_0000_00FF});
    do_read(1'b0, {ONES, ONES});
    check("wl_mask_write", DOut, 64'h0000_0000_0000_00FF);

    do_read(1'b1, {64'hF0F0_F0F0_F0F0_F0F0, ZERO});
    check("wl_mask_read", DOut, 64'hF0F0_F0F0_F0F0_F0F0);

    do_write(1'b0, 64'h100, ~64'h100, {ZERO, ONES});
    do_compute(1'b0, {ONES, ONES}, {ZERO, 64'h100});
    check("compute_exact", DOut, 64'h200);

    do_write(1'b0, 64'h0FF, ~64'h0FF, {ZERO, ONES});
    do_compute(1'b0, {ONES, ONES}, {ZERO, 64'h081});
    check("compute_approx", DOut, 64'h1FF);

    do_write(1'b0, ONES, ZERO, {ZERO, ONES});
    do_compute(1'b0, {ONES, ONES}, {ZERO, 64'h100});
    check("compute_wrap", DOut, 64'hFF);

    // Row 1 operand slice: low FF|80, carry 1, upper all-ones + 1 + 1 wraps to 1
    do_compute(1'b1, {ONES, ONES}, {64'h180, 64'hDEAD_BEEF_0000_0001});
    check("compute_row1_slice", DOut, 64'h1FF);

    do_compute(1'b0, {ONES, 64'h0000_0000_FFFF_0000}, {ZERO, 64'h0001_0000});
    check("compute_wl_mask", DOut, 64'h1_0000_0000);

    // Mid-cycle reset clears DOut at once and wipes the array
    do_read(1'b0, {ONES, ONES});
    check("pre_reset_read", DOut, ONES);
    #2;
    Rst = 1'b0;
    #1;
    check("async_reset_dout", DOut, ZERO);
    WE = 1'b0; wb = 1'b0; Addr = 1'b0; WL = {ONES, ONES};
    #3;
    Rst = 1'b1;
    tick();
    check("async_reset_row0", DOut, ZERO);
    do_read(1'b1, {ONES, ONES});
    check("async_reset_row1", DOut, ZERO);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
